// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronizes the RX line to the system clock and
// reassembles LSB-first frames into bytes using an internal bit-timing counter.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state  <= START;
            o_busy <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end

        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        // Leaving at mid stop bit leaves half a bit to catch a gapless next start.
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              o_data  <= shift;
              o_valid <= 1'b1;
              o_busy  <= 1'b0;
              state   <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        WAIT_IDLE: begin
          clk_cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 16 clocks per bit: stimulus pushes
// expected events, a negedge monitor pops and compares on every output pulse.
module tb_uart_receiver;

  localparam int unsigned CPB = 16;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   valid_cnt;
  int   ferr_cnt;
  logic prev_valid;
  logic prev_ferr;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_rx       (rx),
    .o_data     (data),
    .o_valid    (valid),
    .o_frame_err(frame_err),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && frame_err) check("valid_and_ferr_together", 1, 0);
      if (valid && prev_valid) check("valid_pulse_width", 2, 1);
      if (frame_err && prev_ferr) check("ferr_pulse_width", 2, 1);
      if (valid || frame_err) begin
        if (valid) valid_cnt++;
        if (frame_err) ferr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {valid, frame_err, data}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_kind_is_err", int'(frame_err), int'(e.is_err));
          check("o_data", int'(data), int'(e.data));
        end
      end
    end
    prev_valid = valid;
    prev_ferr  = frame_err;
  end

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic push(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int v0;
    int f0;
    int cyc;
    logic seen_busy;
    checks     = 0;
    failures   = 0;
    valid_cnt  = 0;
    ferr_cnt   = 0;
    prev_valid = 1'b0;
    prev_ferr  = 1'b0;
    rst_n      = 1'b0;
    rx         = 1'b1;

    // Reset with the line toggling.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rx = ~rx;
    end
    check("rst_o_data", int'(data), 0);
    check("rst_o_valid", int'(valid), 0);
    check("rst_o_frame_err", int'(frame_err), 0);
    check("rst_o_busy", int'(busy), 0);
    @(negedge clk);
    rx    = 1'b1;
    rst_n = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_no_pulses", valid_cnt + ferr_cnt, 0);

    // Single byte.
    push(1'b0, 8'h41);
    send_frame(8'h41, 1'b1);
    drain("single_drain");
    check("single_busy_after", int'(busy), 0);
    check("single_valid_cnt", valid_cnt, 1);

    // Back-to-back with zero gap.
    v0 = valid_cnt;
    for (int b = 8'h20; b <= 8'h7E; b++) begin
      push(1'b0, 8'(b));
      send_frame(8'(b), 1'b1);
    end
    drain("b2b_drain");
    check("b2b_valid_cnt", valid_cnt - v0, 95);
    check("b2b_no_ferr", ferr_cnt, 0);

    // Glitch shorter than half a bit.
    repeat (2 * CPB) @(negedge clk);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    cyc = 0;
    seen_busy = 1'b0;
    while (cyc < 4 * CPB && !(seen_busy && !busy)) begin
      if (cyc == CPB / 4 - 1) begin
        @(negedge clk);
        rx = 1'b1;
      end else begin
        @(negedge clk);
      end
      cyc++;
      if (busy) seen_busy = 1'b1;
    end
    check("glitch_busy_seen", int'(seen_busy), 1);
    check("glitch_busy_fall_in_time", int'(cyc <= CPB / 2 + 3), 1);
    repeat (2 * CPB) @(negedge clk);
    check("glitch_no_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    check("glitch_idle_busy", int'(busy), 0);

    // Framing error then a good frame; o_data must still hold 0x7E at the error.
    push(1'b1, 8'h7E);
    send_frame(8'h55, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("ferr_busy_while_low", int'(busy), 1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    push(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1);
    drain("ferr_drain");
    check("ferr_cnt", ferr_cnt, 1);

    // Reset in the middle of an 0xFF frame.
    repeat (2 * CPB) @(negedge clk);
    v0 = valid_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    check("midrst_o_data", int'(data), 0);
    check("midrst_o_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("midrst_no_pulse", valid_cnt - v0, 0);
    push(1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1);
    drain("midrst_drain");
    check("midrst_valid_cnt", valid_cnt - v0, 1);
    check("total_valid_cnt", valid_cnt, 98);

    repeat (CPB) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #50_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage: samples the asynchronous RX line on the system clock and reassembles 8N1 frames (1 start, 8 data LSB-first, 1 stop) into bytes. It is the downstream counterpart of the transmitter; in loopback bring-up it consumes the transmitter's TX output directly. It runs on the raw system clock, not the baud clock, and derives bit timing from an internal counter.

## Interface
- CLKS_PER_BIT, default 104: system clocks per bit (12 MHz / 115200). Legal range 4..65535.
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  asynchronous, active-low reset
- i_rx  input  1  serial line, idle high, asynchronous to i_clk
- o_data  output  8  last correctly framed byte; holds until next good frame
- o_valid  output  1  one-cycle pulse when o_data is updated
- o_frame_err  output  1  one-cycle pulse when the stop bit samples low
- o_busy  output  1  high while a frame is being received

## Operation
- i_rx passes through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop, rx_s.
- Bit counter clk_cnt is 16 bits, bit index bit_idx is 3 bits, shift register is 8 bits.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: clk_cnt=0, o_busy=0. On rx_s==0 -> START.
- START: count to CLKS_PER_BIT/2 - 1 (integer division). At that count: rx_s==0 -> DATA, clk_cnt=0, bit_idx=0; rx_s==1 -> IDLE (glitch reject, no output pulse).
- DATA: count to CLKS_PER_BIT-1; at that count sample rx_s into shift register bit position bit_idx (LSB first), clk_cnt=0. After bit_idx==7 is sampled -> STOP, else bit_idx+1.
- STOP: count to CLKS_PER_BIT-1; at that count sample rx_s. 1: load o_data from shift register, pulse o_valid, -> IDLE. 0: pulse o_frame_err, o_data unchanged, -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1 (line break / framing recovery), then -> IDLE. No new start detection while here.
- o_busy = 1 in START, DATA, STOP, WAIT_IDLE.
- o_valid and o_frame_err are never high in the same cycle and never high for more than one cycle.

## Timing
- Reset values: o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0, state IDLE, synchronizer flops 1.
- Reset asserted mid-frame: immediate return to reset values; partial byte discarded; after release a frame already in progress is resynchronized only on the next high-to-low edge seen from IDLE (a low line at release starts START, which may reject or misframe; that is acceptable).
- Synchronizer latency: 2 clocks from i_rx edge to rx_s.
- Start edge on i_rx at cycle 0 -> rx_s low at cycle 2 -> START entered cycle 3.
- Sample points land at mid-bit: start at +CLKS_PER_BIT/2, data bit n at +CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT, stop at +CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (relative to START entry, +/-1 clock).
- o_valid/o_frame_err asserted in the cycle after the stop sample; o_data valid in the same cycle as o_valid.
- Back-to-back frames with no idle gap between stop bit and next start bit are received without loss (return to IDLE occurs mid stop bit).
- Tolerates transmitter baud mismatch up to +/-3% at CLKS_PER_BIT>=16.

## Test plan
- Reset: hold i_rst=0 with i_rx toggling -> all outputs at reset values; release, i_rx=1 for 20 bit times -> no pulses, o_busy=0.
- Single byte, CLKS_PER_BIT=16: send 8'h41 (8N1) -> exactly one o_valid pulse, o_data=8'h41, o_frame_err never high, o_busy low after stop.
- Back-to-back: send 8'h20 through 8'h7E with zero inter-frame gap -> 95 o_valid pulses, bytes in order, no frame errors.
- Glitch reject: drive i_rx low for CLKS_PER_BIT/4 clocks then high -> no o_valid, no o_frame_err, state back to IDLE, o_busy falls within CLKS_PER_BIT/2 + 3 clocks.
- Framing error: send 8'h55 with stop bit 0, hold line low 3 bit times, then send 8'hA5 correctly -> one o_frame_err pulse, o_data stays at prior value, then o_valid with o_data=8'hA5.
- Reset mid-frame: assert i_rst after bit 3 of 8'hFF, release, send 8'h3C -> no output for the aborted frame, then o_data=8'h3C with one o_valid.
